// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared prediction record type and PC step for branch resolution
package branch_resolve_unit_pkg;

  // Record fields are sized for the widest supported PC; narrower XLEN values are zero-extended.
  localparam int PC_W = 64;
  localparam logic [PC_W-1:0] PC_INC = 64'd4;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
  } pred_rec_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch/execute/predictor signal bundle for the branch resolve unit
interface branch_resolve_unit_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
);

  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] pred_target;
  logic            pred_ready;

  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_target;

  logic            upd_valid;
  logic            upd_taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            underflow;
  logic [CNTW-1:0] stat_branches;
  logic [CNTW-1:0] stat_mispredicts;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_taken, mispredict, redirect_pc,
    input  underflow, stat_branches, stat_mispredicts
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_taken, mispredict, redirect_pc,
    output underflow, stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/branch_resolve_unit_pred_fifo.sv
// rtl/branch_resolve_unit_pred_fifo.sv - in-flight prediction FIFO with whole-queue flush
module pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  pred_rec_t push_data,
  input  logic      pop,
  output pred_rec_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  pred_rec_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Flush wins over any same-cycle push or pop so squashed work never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - compares resolved branches with queued predictions, drives redirect and stats
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNTW  = 16
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  pred_rec_t       push_rec;
  pred_rec_t       head;
  logic            full;
  logic            empty;
  logic            res_fire;
  logic            mismatch;
  logic            flush;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] res_target_ext;
  logic [XLEN-1:0] redirect_next;

  logic            upd_valid_q;
  logic            upd_taken_q;
  logic            mispredict_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            underflow_q;
  logic [CNTW-1:0] stat_branches_q;
  logic [CNTW-1:0] stat_mispredicts_q;

  always_comb begin
    push_rec        = '0;
    push_rec.taken  = bus.pred_taken;
    push_rec.pc     = PC_W'(bus.pred_pc);
    push_rec.target = PC_W'(bus.pred_target);
  end

  assign res_target_ext = PC_W'(bus.res_target);
  assign res_fire       = bus.res_valid && !empty;
  assign mismatch       = (bus.res_taken != head.taken) ||
                          (bus.res_taken && head.taken && (res_target_ext != head.target));
  assign flush          = res_fire && mismatch;
  assign pop            = res_fire && !mismatch;
  assign push           = bus.pred_valid && !full && !flush;
  // Fall-through PC wraps at XLEN bits.
  assign redirect_next  = bus.res_taken ? bus.res_target : XLEN'(head.pc + PC_INC);

  pred_fifo #(
    .DEPTH(DEPTH)
  ) u_pred_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data(push_rec),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q        <= 1'b0;
      upd_taken_q        <= 1'b0;
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= '0;
      underflow_q        <= 1'b0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      upd_valid_q  <= res_fire;
      upd_taken_q  <= res_fire && bus.res_taken;
      mispredict_q <= flush;
      if (res_fire) redirect_pc_q <= redirect_next;
      if (bus.res_valid && empty) underflow_q <= 1'b1;
      if (res_fire && (stat_branches_q != CNT_MAX))
        stat_branches_q <= stat_branches_q + 1'b1;
      if (flush && (stat_mispredicts_q != CNT_MAX))
        stat_mispredicts_q <= stat_mispredicts_q + 1'b1;
    end
  end

  assign bus.pred_ready       = !full;
  assign bus.upd_valid        = upd_valid_q;
  assign bus.upd_taken        = upd_taken_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.underflow        = underflow_q;
  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight prediction FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, PC/target width.
REQ-003 SHALL have parameter CNTW, default 16, statistics counter width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pred_valid  input  1  fetch pushes one prediction record this cycle.
REQ-007 pred_taken  input  1  predictor output for this branch (1 = taken).
REQ-008 pred_pc  input  XLEN  PC of the predicted branch.
REQ-009 pred_target  input  XLEN  predicted taken target.
REQ-010 pred_ready  output  1  FIFO not full; push accepted only when pred_valid and pred_ready.
REQ-011 res_valid  input  1  execute resolves the oldest in-flight branch this cycle.
REQ-012 res_taken  input  1  actual outcome (PCSrc).
REQ-013 res_target  input  XLEN  actual computed target.
REQ-014 upd_valid  output  1  registered; strobe to predictor branch input.
REQ-015 upd_taken  output  1  registered; actual outcome to predictor PCSrc input.
REQ-016 mispredict  output  1  registered one-cycle flush/redirect pulse.
REQ-017 redirect_pc  output  XLEN  registered; correct next PC, valid while mispredict=1.
REQ-018 underflow  output  1  sticky error: res_valid seen with FIFO empty.
REQ-019 stat_branches, stat_mispredicts  output  CNTW each  saturating counters.

Function
REQ-020 FIFO SHALL store {pred_taken, pred_pc, pred_target} in push order; occupancy 0..DEPTH.
REQ-021 pred_ready SHALL be 1 iff occupancy < DEPTH (no same-cycle pop bypass).
REQ-022 Resolution SHALL pop head when res_valid=1 and occupancy>0.
REQ-023 Mismatch SHALL be: res_taken != head.pred_taken, or both taken and res_target != head.pred_target.
REQ-024 Latency: resolution at edge N SHALL produce upd_valid=1, upd_taken=res_taken, mispredict, redirect_pc after edge N, held for exactly one cycle.
REQ-025 redirect_pc SHALL be res_target if res_taken, else head.pred_pc + 4 (mod 2^XLEN, wraps).
REQ-026 On mismatch, edge N SHALL empty the FIFO (all younger entries squashed) and drop any same-cycle push.
REQ-027 On match, same-cycle push and pop SHALL both take effect; occupancy unchanged.
REQ-028 res_valid with occupancy=0 SHALL set underflow, produce no upd_valid/mispredict, leave counters unchanged; a same-cycle push SHALL still be accepted.
REQ-029 stat_branches SHALL increment per valid resolution; stat_mispredicts per mismatch; both saturate at 2^CNTW-1.
REQ-030 Pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.
REQ-031 Outputs with no event SHALL be 0 (upd_valid, upd_taken, mispredict); redirect_pc holds last value.

Reset
REQ-032 rst=1 SHALL immediately clear FIFO (occupancy 0), upd_valid=0, upd_taken=0, mispredict=0, redirect_pc=0, underflow=0, both counters=0; pred_ready=1.
REQ-033 rst asserted mid-operation SHALL discard all in-flight entries with no pending pulse emitted after release.

Structure
REQ-034 Shared package SHALL hold the prediction-record typedef {taken, pc, target} and the PC increment constant 4.
REQ-035 One sub-module, pred_fifo (parameterised synchronous FIFO with flush input), SHALL hold storage and pointers; compare/redirect/counters in the top.

Verification
REQ-036 Push {T, 0x100, 0x200}; resolve taken, target 0x200 -> next cycle upd_valid=1, upd_taken=1, mispredict=0, stat_branches=1.
REQ-037 Push {NT, 0x100, 0x200}; resolve taken 0x200 -> mispredict=1, redirect_pc=0x200, stat_mispredicts=1, FIFO empty.
REQ-038 Push {T, 0x300, 0x400}, {T,0x500,0x600}; resolve not-taken -> redirect_pc=0x304, second entry squashed, pred_ready=1.
REQ-039 Push DEPTH entries -> pred_ready=0; push+resolve match same cycle -> pop accepted, push rejected, occupancy DEPTH-1 then push accepted.
REQ-040 res_valid on empty FIFO -> underflow=1 sticky, upd_valid=0; rst -> underflow=0.
REQ-041 Preload counters near max (CNTW=2): 4 mispredicts -> both counters hold 3.
